// File: rtl/display_mode_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// display_mode_sequencer_pkg
// Shared definitions for the display mode sequencer:
//   - sequencer state codes (also published on o_state)
//   - display mode index constants
//   - per-mode timing/clock parameter table used by the parameter mux that
//     follows o_mode
// No ports (package).
// -----------------------------------------------------------------------------
package display_mode_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_CLK_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_DARK      = 3'd3,
    ST_RUN       = 3'd4,
    ST_DRAIN     = 3'd5
  } seq_state_e;

  localparam logic [1:0] MODE_640X480   = 2'd0;
  localparam logic [1:0] MODE_800X600   = 2'd1;
  localparam logic [1:0] MODE_1280X720  = 2'd2;
  localparam logic [1:0] MODE_1920X1080 = 2'd3;

  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] v_active;
    logic [17:0] pclk_khz;
  } mode_timing_t;

  // Parameter table looked up by the timing/clock mux from o_mode.
  function automatic mode_timing_t mode_timing(input logic [1:0] mode);
    mode_timing_t t;
    case (mode)
      MODE_800X600:   t = '{h_active: 12'd800,  v_active: 12'd600,  pclk_khz: 18'd40000};
      MODE_1280X720:  t = '{h_active: 12'd1280, v_active: 12'd720,  pclk_khz: 18'd74250};
      MODE_1920X1080: t = '{h_active: 12'd1920, v_active: 12'd1080, pclk_khz: 18'd148500};
      default:        t = '{h_active: 12'd640,  v_active: 12'd480,  pclk_khz: 18'd25175};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/xd_sync_2ff.sv
// -----------------------------------------------------------------------------
// xd_sync_2ff
// Two-flop synchroniser for quasi-static or toggle signals entering the
// i_clk domain.
// Ports:
//   i_clk    in  1      destination clock
//   i_rst_n  in  1      asynchronous active-low reset
//   i_d      in  WIDTH  asynchronous input
//   o_q      out WIDTH  synchronised output (2 cycles latency)
// -----------------------------------------------------------------------------
module xd_sync_2ff #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/display_mode_sequencer.sv
// -----------------------------------------------------------------------------
// display_mode_sequencer
// Power-up and mode-change sequencer for the display pipeline: holds the
// display clock generator in reset, waits for stable lock, releases the
// timing generator, keeps DVI output dark for DARK_FRAMES frames, then
// enables it. Recovers from lock loss and switches modes at frame boundaries.
// Ports:
//   i_clk       in  1       board clock
//   i_rst_n     in  1       asynchronous active-low reset
//   i_mode_req  in  MODE_W  requested mode, sampled when i_mode_stb=1
//   i_mode_stb  in  1       one-cycle request strobe
//   i_locked    in  1       clock generator lock (asynchronous)
//   i_frame_tgl in  1       toggles once per frame start (pixel domain)
//   o_clk_rst   out 1       reset to display clock generator
//   o_tim_rst   out 1       reset to timing generator
//   o_mode      out MODE_W  active mode index
//   o_out_en    out 1       DVI output enable
//   o_busy      out 1       high in every state except RUN
//   o_err       out 1       sticky lock-timeout flag
//   o_state     out 3       current state code
// -----------------------------------------------------------------------------
module display_mode_sequencer
  import display_mode_sequencer_pkg::*;
#(
  parameter int MODE_W        = 2,
  parameter int DEFAULT_MODE  = 0,
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1000000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int DARK_FRAMES   = 2,
  parameter int DRAIN_TIMEOUT = 2000000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [MODE_W-1:0] i_mode_req,
  input  logic              i_mode_stb,
  input  logic              i_locked,
  input  logic              i_frame_tgl,
  output logic              o_clk_rst,
  output logic              o_tim_rst,
  output logic [MODE_W-1:0] o_mode,
  output logic              o_out_en,
  output logic              o_busy,
  output logic              o_err,
  output logic [2:0]        o_state
);

  localparam int RST_W    = $clog2(RST_CYCLES + 1);
  localparam int TO_W     = $clog2(LOCK_TIMEOUT + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int FRAME_W  = $clog2(DARK_FRAMES + 1);
  localparam int DRAIN_W  = $clog2(DRAIN_TIMEOUT + 1);

  // Terminal values: a state exits when its counter already holds N-1, so
  // the state occupies exactly N cycles.
  localparam logic [RST_W-1:0]    RST_LAST    = RST_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [FRAME_W-1:0]  FRAME_LAST  = FRAME_W'(DARK_FRAMES - 1);
  localparam logic [DRAIN_W-1:0]  DRAIN_LAST  = DRAIN_W'(DRAIN_TIMEOUT - 1);

  logic w_locked_s;
  logic w_frame_s;
  logic w_frame_evt;

  seq_state_e          r_state;
  logic                r_clk_rst;
  logic                r_tim_rst;
  logic [MODE_W-1:0]   r_mode;
  logic                r_out_en;
  logic                r_busy;
  logic                r_err;
  logic [MODE_W-1:0]   r_pend_mode;
  logic                r_pend_vld;
  logic                r_frame_d;
  logic [RST_W-1:0]    r_rst_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [FRAME_W-1:0]  r_frame_cnt;
  logic [DRAIN_W-1:0]  r_drain_cnt;

  xd_sync_2ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_lock (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_locked),
    .o_q     (w_locked_s)
  );

  xd_sync_2ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_sync_frame (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_frame_tgl),
    .o_q     (w_frame_s)
  );

  // Any edge of the synchronised toggle marks a frame start.
  assign w_frame_evt = w_frame_s ^ r_frame_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_CLK_RST;
      r_clk_rst    <= 1'b1;
      r_tim_rst    <= 1'b1;
      r_mode       <= MODE_W'(DEFAULT_MODE);
      r_out_en     <= 1'b0;
      r_busy       <= 1'b1;
      r_err        <= 1'b0;
      r_pend_mode  <= '0;
      r_pend_vld   <= 1'b0;
      r_frame_d    <= 1'b0;
      r_rst_cnt    <= '0;
      r_to_cnt     <= '0;
      r_settle_cnt <= '0;
      r_frame_cnt  <= '0;
      r_drain_cnt  <= '0;
    end else begin
      r_frame_d <= w_frame_s;

      // Each counter is cleared when its state exits, so it starts at zero
      // on every entry.
      case (r_state)
        ST_CLK_RST: begin
          if (r_rst_cnt == RST_LAST) begin
            r_rst_cnt <= '0;
            r_clk_rst <= 1'b0;
            r_state   <= ST_WAIT_LOCK;
          end else if (r_rst_cnt < RST_LAST) begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (w_locked_s) begin
            r_to_cnt <= '0;
            r_state  <= ST_SETTLE;
          end else if (r_to_cnt == TO_LAST) begin
            r_to_cnt  <= '0;
            r_err     <= 1'b1;
            r_clk_rst <= 1'b1;
            r_state   <= ST_CLK_RST;
          end else if (r_to_cnt < TO_LAST) begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        ST_SETTLE: begin
          if (!w_locked_s) begin
            r_settle_cnt <= '0;
            r_state      <= ST_WAIT_LOCK;
          end else if (r_settle_cnt == SETTLE_LAST) begin
            r_settle_cnt <= '0;
            r_tim_rst    <= 1'b0;
            r_state      <= ST_DARK;
          end else if (r_settle_cnt < SETTLE_LAST) begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end

        ST_DARK: begin
          if (!w_locked_s) begin
            r_frame_cnt <= '0;
            r_tim_rst   <= 1'b1;
            r_out_en    <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_WAIT_LOCK;
          end else if (w_frame_evt) begin
            if (r_frame_cnt == FRAME_LAST) begin
              r_frame_cnt <= '0;
              r_out_en    <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= ST_RUN;
            end else if (r_frame_cnt < FRAME_LAST) begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (!w_locked_s) begin
            r_tim_rst <= 1'b1;
            r_out_en  <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_WAIT_LOCK;
          end else if (r_pend_vld) begin
            if (r_pend_mode != r_mode) begin
              r_out_en <= 1'b0;
              r_busy   <= 1'b1;
              r_state  <= ST_DRAIN;
            end else begin
              r_pend_vld <= 1'b0;
            end
          end
        end

        ST_DRAIN: begin
          if (!w_locked_s) begin
            r_drain_cnt <= '0;
            r_tim_rst   <= 1'b1;
            r_state     <= ST_WAIT_LOCK;
          end else if (w_frame_evt || (r_drain_cnt == DRAIN_LAST)) begin
            r_drain_cnt <= '0;
            r_mode      <= r_pend_mode;
            r_pend_vld  <= 1'b0;
            r_clk_rst   <= 1'b1;
            r_tim_rst   <= 1'b1;
            r_state     <= ST_CLK_RST;
          end else if (r_drain_cnt < DRAIN_LAST) begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end

        default: begin
          r_clk_rst <= 1'b1;
          r_tim_rst <= 1'b1;
          r_out_en  <= 1'b0;
          r_busy    <= 1'b1;
          r_state   <= ST_CLK_RST;
        end
      endcase

      // Placed after the FSM so a strobe overrides any clear issued above,
      // including the clear on the DRAIN exit: the newest request survives.
      if (i_mode_stb) begin
        r_pend_mode <= i_mode_req;
        r_pend_vld  <= 1'b1;
      end
    end
  end

  assign o_clk_rst = r_clk_rst;
  assign o_tim_rst = r_tim_rst;
  assign o_mode    = r_mode;
  assign o_out_en  = r_out_en;
  assign o_busy    = r_busy;
  assign o_err     = r_err;
  assign o_state   = r_state;

endmodule
